// File: rtl/palette_lookup_arbiter_if.sv
// -----------------------------------------------------------------------------
// palette_lookup_arbiter_if
//   Bundles the requester-side and palette-side signals of the palette lookup
//   arbiter.
//
//   Signals
//     req            per-requester lookup request (level)
//     index          flattened indices, requester k uses [k*IDX_W +: IDX_W]
//     gnt            one-hot grant, one cycle per accepted request
//     pal_index      index driven to the shared palette
//     pal_red/green/blue  combinational palette response to pal_index
//     rd_valid       one-hot result strobe
//     rd_rgb         {red, green, blue} for the strobed requester
//     rd_transparent looked-up index was 0 (colour key)
//     busy           any gnt or rd_valid bit high
//
//   Modports
//     master  surroundings of the arbiter: requesters plus the palette
//     slave   the arbiter itself
// -----------------------------------------------------------------------------
interface palette_lookup_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 8
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*IDX_W-1:0] index;
   logic [NUM_REQ-1:0]       gnt;
   logic [IDX_W-1:0]         pal_index;
   logic [3:0]               pal_red;
   logic [3:0]               pal_green;
   logic [3:0]               pal_blue;
   logic [NUM_REQ-1:0]       rd_valid;
   logic [11:0]              rd_rgb;
   logic                     rd_transparent;
   logic                     busy;

   modport master (
      output req, index, pal_red, pal_green, pal_blue,
      input  gnt, pal_index, rd_valid, rd_rgb, rd_transparent, busy
   );

   modport slave (
      input  req, index, pal_red, pal_green, pal_blue,
      output gnt, pal_index, rd_valid, rd_rgb, rd_transparent, busy
   );
endinterface

// File: rtl/palette_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// palette_lookup_arbiter
//   Time-shares one combinational 4:4:4 sprite palette among NUM_REQ
//   requesters. Stage A picks one eligible requester per cycle, registers its
//   index onto pal_index and raises its grant for one cycle. Stage B captures
//   the palette colour one cycle later and strobes rd_valid for the requester
//   that was granted.
//
//   Ports
//     Clk      system clock, rising edge
//     Reset_n  asynchronous active-low reset
//     bus      palette_lookup_arbiter_if.slave (req/index in, gnt/pal_index
//              out, palette colour in, rd_valid/rd_rgb/rd_transparent/busy out)
//
//   Configuration
//     PAL_ARB_ROUND_ROBIN_EN  defined: round-robin from a rotating pointer.
//                             undefined: fixed priority, lowest index wins.
// -----------------------------------------------------------------------------
module palette_lookup_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 8
) (
   input logic                     Clk,
   input logic                     Reset_n,
   palette_lookup_arbiter_if.slave bus
);

   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [NUM_REQ-1:0] elig_s;
   logic               any_s;
   logic [TAG_W-1:0]   win_s;
   logic [IDX_W-1:0]   win_idx_s;

   logic [NUM_REQ-1:0] gnt_d,       gnt_q;
   logic [IDX_W-1:0]   pal_index_d, pal_index_q;
   logic [TAG_W-1:0]   tag_d,       tag_q;
   logic [NUM_REQ-1:0] rd_valid_d,  rd_valid_q;
   logic [11:0]        rd_rgb_d,    rd_rgb_q;
   logic               rd_tr_d,     rd_tr_q;
   logic               busy_d,      busy_q;

`ifdef PAL_ARB_ROUND_ROBIN_EN
   logic [TAG_W-1:0]   ptr_d, ptr_q;
   int                 dist_s;
   int                 best_dist_s;
   logic               take_s;
`endif

   // Winner selection: the requester currently granted is masked so a held
   // req cannot win two cycles in a row.
   always_comb begin
      elig_s    = bus.req & ~gnt_q;
      any_s     = |elig_s;
      win_s     = {TAG_W{1'b0}};
      win_idx_s = {IDX_W{1'b0}};
`ifdef PAL_ARB_ROUND_ROBIN_EN
      // Smallest upward distance from ptr (with wrap) among eligible wins.
      best_dist_s = NUM_REQ;
      dist_s      = 0;
      take_s      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         dist_s      = (i + NUM_REQ - int'(ptr_q)) % NUM_REQ;
         take_s      = elig_s[i] && (dist_s < best_dist_s);
         win_s       = take_s ? TAG_W'(i) : win_s;
         win_idx_s   = take_s ? bus.index[i*IDX_W +: IDX_W] : win_idx_s;
         best_dist_s = take_s ? dist_s : best_dist_s;
      end
`else
      // Scanning downward leaves the lowest eligible requester selected.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         win_s     = elig_s[i] ? TAG_W'(i) : win_s;
         win_idx_s = elig_s[i] ? bus.index[i*IDX_W +: IDX_W] : win_idx_s;
      end
`endif
   end

   // Next-state for both pipeline stages and the busy flag.
   always_comb begin
      gnt_d       = {NUM_REQ{1'b0}};
      pal_index_d = pal_index_q;
      tag_d       = tag_q;
      rd_valid_d  = {NUM_REQ{1'b0}};
      rd_rgb_d    = rd_rgb_q;
      rd_tr_d     = rd_tr_q;

      // Stage A: issue a grant; pal_index and tag hold when idle.
      if (any_s) begin
         gnt_d       = ONE_HOT0 << win_s;
         pal_index_d = win_idx_s;
         tag_d       = win_s;
      end else begin
         gnt_d       = {NUM_REQ{1'b0}};
      end

      // Stage B: the palette is answering for pal_index_q during a grant cycle.
      if (|gnt_q) begin
         rd_valid_d = ONE_HOT0 << tag_q;
         rd_rgb_d   = {bus.pal_red, bus.pal_green, bus.pal_blue};
         rd_tr_d    = (pal_index_q == {IDX_W{1'b0}});
      end else begin
         rd_valid_d = {NUM_REQ{1'b0}};
      end

      busy_d = (|gnt_d) | (|rd_valid_d);
   end

`ifdef PAL_ARB_ROUND_ROBIN_EN
   // Pointer moves to the requester just above the latest winner.
   always_comb begin
      ptr_d = ptr_q;
      if (any_s) begin
         if (win_s == TAG_W'(NUM_REQ - 1)) begin
            ptr_d = {TAG_W{1'b0}};
         end else begin
            ptr_d = win_s + TAG_W'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ptr_q <= {TAG_W{1'b0}};
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Pipeline registers; reset discards any lookup in flight.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         gnt_q       <= {NUM_REQ{1'b0}};
         pal_index_q <= {IDX_W{1'b0}};
         tag_q       <= {TAG_W{1'b0}};
         rd_valid_q  <= {NUM_REQ{1'b0}};
         rd_rgb_q    <= 12'h000;
         rd_tr_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         gnt_q       <= gnt_d;
         pal_index_q <= pal_index_d;
         tag_q       <= tag_d;
         rd_valid_q  <= rd_valid_d;
         rd_rgb_q    <= rd_rgb_d;
         rd_tr_q     <= rd_tr_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.gnt            = gnt_q;
   assign bus.pal_index      = pal_index_q;
   assign bus.rd_valid       = rd_valid_q;
   assign bus.rd_rgb         = rd_rgb_q;
   assign bus.rd_transparent = rd_tr_q;
   assign bus.busy           = busy_q;

endmodule
